// File: rtl/psec6_spi_pkg.sv
// Shared constants and types for the SPI slave read path.
package psec6_spi_pkg;

  localparam int unsigned NUM_GLOB     = 11;
  localparam int unsigned NUM_CH       = 8;
  localparam int unsigned REGS_PER_CH  = 7;
  localparam int unsigned CH_BASE_ADDR = NUM_GLOB;
  localparam int unsigned LAST_ADDR    = CH_BASE_ADDR + NUM_CH * REGS_PER_CH - 1;
  localparam int unsigned ADDR_W       = 7;
  localparam int unsigned WORD_W       = 8;

  typedef enum logic {IDLE, SHIFT} rd_state_t;

endpackage

// File: rtl/spi_piso_shifter.sv
// Parallel-load, MSB-first shift register with a bit counter that flags the last bit of a word.
module spi_piso_shifter #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_word,
  output logic         o_msb,
  output logic         o_word_last
);

  localparam int unsigned CntW = $clog2(W);

  logic [W-1:0]    r_shift;
  logic [CntW-1:0] r_cnt;

  // Load has priority so a restart or burst reload never loses the new word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= CntW'(W - 1);
    end else if (i_shift) begin
      r_shift <= {r_shift[W-2:0], 1'b0};
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  assign o_msb       = r_shift[W-1];
  assign o_word_last = (r_cnt == '0);

endmodule

// File: rtl/spi_readout_serializer.sv
// SPI read-path serializer: maps a register address to a word and shifts it out MSB first,
// auto-incrementing the address for gap-free burst reads.
module spi_readout_serializer
  import psec6_spi_pkg::*;
(
  input  logic                                  spi_clk,
  input  logic                                  rstn,
  input  logic                                  cs,
  input  logic [ADDR_W-1:0]                     addr,
  input  logic                                  addr_valid,
  input  logic [NUM_GLOB*WORD_W-1:0]            glob_regs,
  input  logic [NUM_CH*REGS_PER_CH*WORD_W-1:0]  ch_regs,
  output logic                                  miso,
  output logic                                  miso_oe,
  output logic [ADDR_W-1:0]                     rd_addr,
  output logic                                  rd_strobe
);

  localparam int unsigned ChW = $clog2(NUM_CH);

  rd_state_t         r_state, w_state_next;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_strobe;
  logic              w_rst_n;
  logic              w_load, w_shift, w_msb, w_word_last;
  logic [ADDR_W-1:0] w_load_addr, w_off, w_sel, w_idx;
  logic [ChW-1:0]    w_ch;
  logic [WORD_W-1:0] w_word;

  // Dropping chip select clears the read path exactly like reset.
  assign w_rst_n = rstn & cs;

  always_ff @(posedge spi_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (addr_valid) w_state_next = SHIFT;
      SHIFT:   w_state_next = SHIFT;
      default: w_state_next = IDLE;
    endcase
  end

  // A new address aborts the word in flight; otherwise reload at the last bit for bursts.
  always_comb begin
    w_load  = 1'b0;
    w_shift = 1'b0;
    miso    = 1'b0;
    miso_oe = 1'b0;
    unique case (r_state)
      IDLE: w_load = addr_valid;
      SHIFT: begin
        w_load  = addr_valid | w_word_last;
        w_shift = ~w_load;
        miso    = w_msb;
        miso_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_load_addr = addr_valid ? addr : r_rd_addr + 1'b1;
  assign w_off       = w_load_addr - ADDR_W'(CH_BASE_ADDR);

  // Channel/select split by range compare rather than a divider.
  always_comb begin
    w_ch = '0;
    for (int unsigned c = 1; c < NUM_CH; c++) begin
      if (w_off >= ADDR_W'(c * REGS_PER_CH)) w_ch = ChW'(c);
    end
  end

  assign w_sel = w_off - ADDR_W'(w_ch) * ADDR_W'(REGS_PER_CH);
  assign w_idx = ADDR_W'(w_ch) * ADDR_W'(REGS_PER_CH) + w_sel;

  always_comb begin
    w_word = '0;
    if (w_load_addr < ADDR_W'(NUM_GLOB)) begin
      for (int unsigned i = 0; i < NUM_GLOB; i++) begin
        if (w_load_addr == ADDR_W'(i)) w_word = glob_regs[i*WORD_W +: WORD_W];
      end
    end else if (w_load_addr <= ADDR_W'(LAST_ADDR)) begin
      for (int unsigned i = 0; i < NUM_CH * REGS_PER_CH; i++) begin
        if (w_idx == ADDR_W'(i)) w_word = ch_regs[i*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge spi_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rd_addr   <= '0;
      r_rd_strobe <= 1'b0;
    end else begin
      r_rd_strobe <= w_load;
      if (w_load) r_rd_addr <= w_load_addr;
    end
  end

  assign rd_addr   = r_rd_addr;
  assign rd_strobe = r_rd_strobe;

  spi_piso_shifter #(
    .W (WORD_W)
  ) u_shifter (
    .i_clk       (spi_clk),
    .i_rst_n     (w_rst_n),
    .i_load      (w_load),
    .i_shift     (w_shift),
    .i_word      (w_word),
    .o_msb       (w_msb),
    .o_word_last (w_word_last)
  );

endmodule
